// File: rtl/axis_ram_writer_ring.sv
`timescale 1ns/1ps
// Streams AXI4-Stream beats into a DDR ring through AXI3 INCR bursts, one burst outstanding.
// Latency: AW rises the cycle after BURST_LEN beats are buffered; W beats come straight off the FIFO head.
// Backpressure: tready drops only while enabled with the FIFO full; disabled input is accepted and dropped.
module axis_ram_writer_ring #(
    parameter int AXI_ID_WIDTH     = 6,
    parameter int AXI_ADDR_WIDTH   = 32,
    parameter int AXI_DATA_WIDTH   = 64,
    parameter int AXIS_TDATA_WIDTH = 64,
    parameter int BURST_LEN        = 16,
    parameter int ADDR_WIDTH       = 20,
    parameter int COUNTER_WIDTH    = 64,
    parameter int FIFO_DEPTH       = 512
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [AXI_ADDR_WIDTH-1:0]     cfg_base,
    input  logic                          cfg_enable,
    output logic [ADDR_WIDTH-1:0]         sts_addr,
    output logic [COUNTER_WIDTH-1:0]      sts_total,
    output logic                          sts_overflow,
    output logic                          sts_error,
    output logic                          sts_busy,
    output logic [AXI_ID_WIDTH-1:0]       m_axi_awid,
    output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [3:0]                    m_axi_awlen,
    output logic [2:0]                    m_axi_awsize,
    output logic [1:0]                    m_axi_awburst,
    output logic [3:0]                    m_axi_awcache,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [AXI_ID_WIDTH-1:0]       m_axi_wid,
    output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                          m_axi_wlast,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    input  logic                          m_axi_bvalid,
    input  logic [1:0]                    m_axi_bresp,
    output logic                          m_axi_bready,
    output logic                          s_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                          s_axis_tvalid
);
    localparam int SIZE = $clog2(AXI_DATA_WIDTH/8);
    localparam int BW   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] BURST_CNT = CW'(BURST_LEN);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [BW-1:0]               r_beat;
    logic [AXI_ID_WIDTH-1:0]     r_wid;
    logic [ADDR_WIDTH-1:0]       r_sts_addr;
    logic [COUNTER_WIDTH-1:0]    r_sts_total;
    logic                        r_ovf;
    logic                        r_err;
    logic [AXI_ADDR_WIDTH-1:0]   r_awaddr;
    logic                        r_live;

    logic [AXIS_TDATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]               r_wr_ptr;
    logic [PW-1:0]               r_rd_ptr;
    logic [CW-1:0]               r_fifo_cnt;

    logic w_aw_vld, w_w_vld, w_b_rdy, w_flush, w_start;
    logic w_full, w_tready, w_push, w_pop, w_last, w_b_fire, w_ovf_evt;

    assign w_full    = (r_fifo_cnt == FULL_CNT);
    // r_live holds tready low from reset assertion until the first clock after release.
    assign w_tready  = r_live & (~w_full | ~cfg_enable);
    assign w_push    = s_axis_tvalid & w_tready & cfg_enable;
    assign w_pop     = w_w_vld & m_axi_wready;
    assign w_last    = (r_beat == LAST_BEAT);
    assign w_b_fire  = w_b_rdy & m_axi_bvalid;
    assign w_ovf_evt = cfg_enable & s_axis_tvalid & w_full;

    always_comb begin
        w_state_nxt = r_state;
        w_aw_vld    = 1'b0;
        w_w_vld     = 1'b0;
        w_b_rdy     = 1'b0;
        w_flush     = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!cfg_enable) begin
                    w_flush = 1'b1;
                end else if (r_fifo_cnt >= BURST_CNT) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                w_aw_vld = 1'b1;
                if (m_axi_awready) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                w_w_vld = 1'b1;
                if (m_axi_wready && w_last) w_state_nxt = S_RESP;
            end
            S_RESP: begin
                w_b_rdy = 1'b1;
                if (m_axi_bvalid) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge aclk) begin
        if (w_push) r_mem[r_wr_ptr] <= s_axis_tdata;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else if (w_flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_live      <= 1'b0;
            r_beat      <= '0;
            r_wid       <= '0;
            r_sts_addr  <= '0;
            r_sts_total <= '0;
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
            r_awaddr    <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_start) r_awaddr <= cfg_base + (AXI_ADDR_WIDTH'(r_sts_addr) << SIZE);
            if (w_pop) begin
                r_beat      <= w_last ? '0 : r_beat + 1'b1;
                r_sts_addr  <= r_sts_addr + 1'b1;
                r_sts_total <= r_sts_total + 1'b1;
            end
            if (w_b_fire) begin
                r_wid <= r_wid + 1'b1;
                if (m_axi_bresp != 2'b00) r_err <= 1'b1;
            end
            if (w_ovf_evt) r_ovf <= 1'b1;
            // Flush only happens in IDLE, so it never races the burst updates above.
            if (w_flush) begin
                r_sts_addr  <= '0;
                r_sts_total <= '0;
                r_ovf       <= 1'b0;
                r_err       <= 1'b0;
            end
        end
    end

    assign m_axi_awid    = r_wid;
    assign m_axi_awaddr  = r_awaddr;
    assign m_axi_awlen   = 4'(BURST_LEN - 1);
    assign m_axi_awsize  = 3'(SIZE);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awvalid = w_aw_vld;
    assign m_axi_wid     = r_wid;
    assign m_axi_wdata   = AXI_DATA_WIDTH'(r_mem[r_rd_ptr]);
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = w_w_vld & w_last;
    assign m_axi_wvalid  = w_w_vld;
    assign m_axi_bready  = w_b_rdy;
    assign s_axis_tready = w_tready;
    assign sts_addr      = r_sts_addr;
    assign sts_total     = r_sts_total;
    assign sts_overflow  = r_ovf;
    assign sts_error     = r_err;
    assign sts_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_axis_ram_writer_ring.sv
`timescale 1ns/1ps
// Bench for axis_ram_writer_ring: a 32-beat ring instance checked by a scoreboard and
// row table, plus a BURST_LEN=4 / 32-bit instance for encodings and asynchronous reset.
module tb_axis_ram_writer_ring;
    localparam int IDW = 6;
    localparam int BL  = 16;
    localparam int RAW = 5;
    localparam int FD  = 64;
    localparam logic [31:0] BASE   = 32'h1000_0000;
    localparam logic [31:0] BASE_B = 32'h2000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance A
    logic            rst_n, en;
    logic [RAW-1:0]  sts_addr;
    logic [63:0]     sts_total;
    logic            sts_ovf, sts_err, sts_busy;
    logic [IDW-1:0]  awid, wid;
    logic [31:0]     awaddr;
    logic [3:0]      awlen, awcache;
    logic [2:0]      awsize;
    logic [1:0]      awburst, bresp;
    logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [63:0]     wdata, s_tdata;
    logic [7:0]      wstrb;
    logic            s_tready, s_tvalid;

    axis_ram_writer_ring #(
        .AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXIS_TDATA_WIDTH(64),
        .BURST_LEN(BL), .ADDR_WIDTH(RAW), .COUNTER_WIDTH(64), .FIFO_DEPTH(FD)
    ) dut_a (
        .aclk(clk), .aresetn(rst_n), .cfg_base(BASE), .cfg_enable(en),
        .sts_addr(sts_addr), .sts_total(sts_total), .sts_overflow(sts_ovf),
        .sts_error(sts_err), .sts_busy(sts_busy),
        .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awcache(awcache), .m_axi_awvalid(awvalid),
        .m_axi_awready(awready),
        .m_axi_wid(wid), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bvalid(bvalid), .m_axi_bresp(bresp), .m_axi_bready(bready),
        .s_axis_tready(s_tready), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid)
    );

    // instance B
    logic            rst_b, en_b;
    logic [7:0]      b_sts_addr;
    logic [31:0]     b_sts_total;
    logic            b_ovf, b_err, b_busy;
    logic [3:0]      b_awid, b_wid;
    logic [31:0]     b_awaddr, b_wdata, b_tdata;
    logic [3:0]      b_awlen, b_awcache, b_wstrb;
    logic [2:0]      b_awsize;
    logic [1:0]      b_awburst;
    logic            b_awvalid, b_awready, b_wlast, b_wvalid, b_wready;
    logic            b_bvalid, b_bready, b_tready, b_tvalid;

    axis_ram_writer_ring #(
        .AXI_ID_WIDTH(4), .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXIS_TDATA_WIDTH(32),
        .BURST_LEN(4), .ADDR_WIDTH(8), .COUNTER_WIDTH(32), .FIFO_DEPTH(16)
    ) dut_b (
        .aclk(clk), .aresetn(rst_b), .cfg_base(BASE_B), .cfg_enable(en_b),
        .sts_addr(b_sts_addr), .sts_total(b_sts_total), .sts_overflow(b_ovf),
        .sts_error(b_err), .sts_busy(b_busy),
        .m_axi_awid(b_awid), .m_axi_awaddr(b_awaddr), .m_axi_awlen(b_awlen),
        .m_axi_awsize(b_awsize), .m_axi_awburst(b_awburst), .m_axi_awcache(b_awcache),
        .m_axi_awvalid(b_awvalid), .m_axi_awready(b_awready),
        .m_axi_wid(b_wid), .m_axi_wdata(b_wdata), .m_axi_wstrb(b_wstrb), .m_axi_wlast(b_wlast),
        .m_axi_wvalid(b_wvalid), .m_axi_wready(b_wready),
        .m_axi_bvalid(b_bvalid), .m_axi_bresp(2'b00), .m_axi_bready(b_bready),
        .s_axis_tready(b_tready), .s_axis_tdata(b_tdata), .s_axis_tvalid(b_tvalid)
    );

    int total_n = 0;
    int bad_n   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_n++;
        if (act !== exp) begin
            bad_n++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // slave-side responders for instance A
    int         aw_dly = 0;
    int         aw_cnt = 0;
    bit         wr_rand = 0;
    bit         wr_on = 1;
    logic [1:0] bresp_cur = 2'b00;

    always @(posedge clk) begin
        #1;
        aw_cnt  = awvalid ? aw_cnt + 1 : 0;
        awready = awvalid && (aw_cnt > aw_dly);
        wready  = wr_rand ? ($urandom_range(0, 1) != 0) : wr_on;
        bvalid  = bready;
        bresp   = bready ? bresp_cur : 2'b00;
        b_bvalid = b_bready;
    end

    // scoreboard: accepted stream beats are the expected W data, in order
    logic [63:0]    q_w[$];
    int             m_occ, m_beat, w_seen;
    logic [RAW-1:0] m_addr;
    logic [63:0]    m_total;
    logic [IDW-1:0] m_wid;
    bit             m_busy, m_aph, m_wph, m_bph, m_ovf, m_err;
    bit             aw_pend;
    logic [31:0]    aw_hold;

    always @(negedge clk) begin
        bit push, pop, awf, bf, busy0;
        int occ0;
        if (!rst_n) begin
            q_w.delete();
            m_occ = 0; m_beat = 0; m_addr = '0; m_total = '0; m_wid = '0;
            m_busy = 0; m_aph = 0; m_wph = 0; m_bph = 0; m_ovf = 0; m_err = 0;
            aw_pend = 0; w_seen = 0;
        end else begin
            check("busy", {63'd0, sts_busy}, {63'd0, m_busy});
            check("awvalid", {63'd0, awvalid}, {63'd0, m_aph});
            check("wvalid", {63'd0, wvalid}, {63'd0, m_wph});
            check("bready", {63'd0, bready}, {63'd0, m_bph});
            if (aw_pend) check("awaddr_stable", {32'd0, awaddr}, {32'd0, aw_hold});
            aw_pend = awvalid && !awready;
            aw_hold = awaddr;
            busy0 = m_busy;
            occ0  = m_occ;
            push  = s_tvalid && s_tready && en;
            pop   = wvalid && wready;
            awf   = awvalid && awready;
            bf    = bvalid && bready;
            if (en && occ0 == FD) check("tready_full", {63'd0, s_tready}, 64'd0);
            if (en && s_tvalid && occ0 == FD) m_ovf = 1;
            if (awf) begin
                check("awaddr", {32'd0, awaddr}, {32'd0, BASE + (32'(m_addr) << 3)});
                check("awid", 64'(awid), 64'(m_wid));
                check("awlen", 64'(awlen), 64'd15);
                check("awsize", 64'(awsize), 64'd3);
                check("awburst", 64'(awburst), 64'd1);
                check("awcache", 64'(awcache), 64'd3);
                m_aph = 0; m_wph = 1; m_beat = 0;
            end
            if (pop) begin
                if (q_w.size() == 0) begin
                    total_n++; bad_n++;
                    $display("FAIL w_extra: got beat 0x%0h, want no beat", wdata);
                end else begin
                    check("wdata", wdata, q_w.pop_front());
                end
                check("wlast", {63'd0, wlast}, {63'd0, m_beat == BL - 1});
                check("wid", 64'(wid), 64'(m_wid));
                check("wstrb", 64'(wstrb), 64'hFF);
                m_beat++; m_addr++; m_total++; m_occ--; w_seen++;
                if (m_beat == BL) begin m_wph = 0; m_bph = 1; end
            end
            if (bf) begin
                m_wid++;
                if (bresp != 2'b00) m_err = 1;
                m_bph = 0; m_busy = 0;
            end
            if (push) begin q_w.push_back(s_tdata); m_occ++; end
            if (!busy0 && !en) begin
                q_w.delete();
                m_occ = 0; m_addr = '0; m_total = '0; m_ovf = 0; m_err = 0;
            end else if (!busy0 && en && occ0 >= BL) begin
                m_busy = 1; m_aph = 1;
            end
        end
    end

    logic [31:0] b_aw_q[$];
    logic [3:0]  b_len_q[$];
    logic [2:0]  b_size_q[$];
    always @(negedge clk) begin
        if (rst_b && b_awvalid && b_awready) begin
            b_aw_q.push_back(b_awaddr);
            b_len_q.push_back(b_awlen);
            b_size_q.push_back(b_awsize);
        end
    end

    int d_next = 0;
    task automatic send(input int ncyc);
        bit acc;
        for (int i = 0; i < ncyc; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 64'hA5A5_0000_0000_0000 | 64'(d_next);
            @(negedge clk);
            acc = s_tready;
            @(posedge clk); #1;
            if (acc) d_next++;
        end
        s_tvalid = 1'b0;
    endtask

    task automatic check_sts(input string tag, input logic [63:0] e_total, input logic [RAW-1:0] e_addr,
                             input bit e_busy, input bit e_ovf, input bit e_err);
        check({tag, "_total"}, sts_total, e_total);
        check({tag, "_addr"}, 64'(sts_addr), 64'(e_addr));
        check({tag, "_busy"}, {63'd0, sts_busy}, {63'd0, e_busy});
        check({tag, "_ovf"}, {63'd0, sts_ovf}, {63'd0, e_ovf});
        check({tag, "_err"}, {63'd0, sts_err}, {63'd0, e_err});
    endtask

    typedef struct {
        bit          en;
        int          ncyc;
        int          aw_dly;
        bit          wr_rand;
        bit          hold_w;
        logic [1:0]  bresp;
        logic [63:0] e_total;
        logic [4:0]  e_addr;
        bit          e_busy;
        bit          e_ovf;
        bit          e_err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int w0;
        bit hit;
        vecs[0] = '{1, 32, 0, 0, 0, 2'b00, 64'd32,  5'd0,  0, 0, 0};
        vecs[1] = '{1, 10, 0, 0, 0, 2'b00, 64'd32,  5'd0,  0, 0, 0};
        vecs[2] = '{1,  6, 0, 0, 0, 2'b00, 64'd48,  5'd16, 0, 0, 0};
        vecs[3] = '{1, 32, 5, 1, 0, 2'b00, 64'd80,  5'd16, 0, 0, 0};
        vecs[4] = '{1, 16, 0, 0, 0, 2'b10, 64'd96,  5'd0,  0, 0, 1};
        vecs[5] = '{1, 70, 0, 0, 1, 2'b00, 64'd160, 5'd0,  0, 1, 1};
        vecs[6] = '{0,  5, 0, 0, 0, 2'b00, 64'd0,   5'd0,  0, 0, 0};
        vecs[7] = '{1, 16, 0, 0, 0, 2'b00, 64'd16,  5'd16, 0, 0, 0};

        rst_n = 1'b0; rst_b = 1'b0; en = 1'b0; en_b = 1'b1;
        s_tvalid = 1'b0; s_tdata = '0; b_tvalid = 1'b0; b_tdata = '0;
        b_awready = 1'b1; b_wready = 1'b1;
        #23;
        check("rst_awvalid", {63'd0, awvalid}, 64'd0);
        check("rst_wvalid", {63'd0, wvalid}, 64'd0);
        check("rst_bready", {63'd0, bready}, 64'd0);
        check("rst_tready", {63'd0, s_tready}, 64'd0);
        check("rst_wid", 64'(wid), 64'd0);
        check_sts("rst", 64'd0, 5'd0, 0, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; rst_b = 1'b1;
        repeat (2) @(posedge clk); #1;

        for (int r = 0; r < 8; r++) begin
            en = vecs[r].en; aw_dly = vecs[r].aw_dly; wr_rand = vecs[r].wr_rand;
            wr_on = !vecs[r].hold_w; bresp_cur = vecs[r].bresp;
            send(vecs[r].ncyc);
            wr_on = 1'b1;
            repeat (300) @(posedge clk); #1;
            check_sts($sformatf("row%0d", r), vecs[r].e_total, vecs[r].e_addr,
                      vecs[r].e_busy, vecs[r].e_ovf, vecs[r].e_err);
        end

        // enable dropped while a burst is in DATA: burst completes, then the flush
        wr_rand = 1'b0; wr_on = 1'b0; aw_dly = 0; bresp_cur = 2'b00;
        w0 = w_seen;
        send(20);
        hit = 0;
        for (int i = 0; i < 50 && !hit; i++) begin
            if (wvalid) hit = 1; else begin @(posedge clk); #1; end
        end
        check("midburst_reached_data", {63'd0, hit}, 64'd1);
        en = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("midburst_busy_held", {63'd0, sts_busy}, 64'd1);
        wr_on = 1'b1;
        repeat (100) @(posedge clk); #1;
        check("midburst_beats", 64'(w_seen - w0), 64'd16);
        check_sts("flush", 64'd0, 5'd0, 0, 0, 0);

        // instance B: 4-beat bursts of 32-bit words
        for (int i = 0; i < 8; i++) begin
            b_tvalid = 1'b1; b_tdata = 32'(i);
            @(posedge clk); #1;
        end
        b_tvalid = 1'b0;
        repeat (40) @(posedge clk); #1;
        check("b_bursts", 64'(b_aw_q.size()), 64'd2);
        if (b_aw_q.size() >= 2) begin
            check("b_awaddr0", 64'(b_aw_q[0]), 64'(BASE_B));
            check("b_addr_step", 64'(b_aw_q[1] - b_aw_q[0]), 64'd16);
            check("b_awlen", 64'(b_len_q[0]), 64'd3);
            check("b_awsize", 64'(b_size_q[0]), 64'd2);
        end
        check("b_total", 64'(b_sts_total), 64'd8);
        check("b_addr", 64'(b_sts_addr), 64'd8);

        b_wready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b_tvalid = 1'b1; b_tdata = 32'(100 + i);
            @(posedge clk); #1;
        end
        b_tvalid = 1'b0;
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (b_wvalid) hit = 1; else begin @(posedge clk); #1; end
        end
        check("b_in_data", {63'd0, hit}, 64'd1);
        @(negedge clk); #2;
        rst_b = 1'b0;
        #1;
        check("b_rst_awvalid", {63'd0, b_awvalid}, 64'd0);
        check("b_rst_wvalid", {63'd0, b_wvalid}, 64'd0);
        check("b_rst_tready", {63'd0, b_tready}, 64'd0);
        check("b_rst_busy", {63'd0, b_busy}, 64'd0);
        check("b_rst_total", 64'(b_sts_total), 64'd0);

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

    initial begin
        #1_000_000;
        bad_n++;
        $display("FAIL watchdog: got timeout, want completion");
        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule

// File: doc/axis_ram_writer_ring.md
Name: axis_ram_writer_ring

Overview:
Parametrised AXI3 burst writer that streams AXI4-Stream samples into a DDR ring buffer. It is the successor of the fixed 16-beat FIFO36-based RAM writer, used by the acquisition chain to move ADC data to PS memory. It adds configurable burst length and ring size, a portable inferred FIFO, an enable/flush control, and write-response checking. Overflow and error status are sticky.

Parameters:
AXI_ID_WIDTH, 6, AXI ID width.
AXI_ADDR_WIDTH, 32, byte address width.
AXI_DATA_WIDTH, 64, W data width; power of two, 32..128.
AXIS_TDATA_WIDTH, 64, stream width, <= AXI_DATA_WIDTH; zero-extended into the MSBs of the W beat.
BURST_LEN, 16, beats per burst; power of two, 1..16.
ADDR_WIDTH, 20, ring size is 2^ADDR_WIDTH beats; must be >= log2(BURST_LEN).
COUNTER_WIDTH, 64, width of the total beat counter.
FIFO_DEPTH, 512, internal FIFO depth in beats; power of two, >= 2*BURST_LEN.

Ports:
aclk  in  1  clock
aresetn  in  1  reset; asynchronous, active-low
cfg_base  in  AXI_ADDR_WIDTH  ring base byte address; aligned to ring size in bytes
cfg_enable  in  1  1 = capture; 0 = stop, flush FIFO, clear counters
sts_addr  out  ADDR_WIDTH  beat index of the next W beat within the ring
sts_total  out  COUNTER_WIDTH  total W beats written since enable
sts_overflow  out  1  sticky: stream beat offered while FIFO full
sts_error  out  1  sticky: non-OKAY bresp seen
sts_busy  out  1  FSM not IDLE
m_axi_aw{id,addr,len,size,burst,cache,valid}  out  AXI3 widths  write address channel
m_axi_awready  in  1
m_axi_w{id,data,strb,last,valid}  out  AXI3 widths  write data channel
m_axi_wready  in  1
m_axi_bvalid  in  1
m_axi_bresp  in  2
m_axi_bready  out  1
s_axis_tready  out  1
s_axis_tdata  in  AXIS_TDATA_WIDTH
s_axis_tvalid  in  1

Behaviour:
- Reset (async assert, sync deassert): FSM IDLE; FIFO empty; all valids, bready and tready 0; wid, sts_addr, sts_total 0; sts_overflow, sts_error and sts_busy 0.
- FIFO: synchronous, first-word-fall-through.
  - Push when tvalid & tready.
  - tready = ~full & cfg_enable | ~cfg_enable. When disabled, beats are accepted and discarded.
  - sts_overflow sets on cfg_enable & tvalid & full.
- FSM IDLE:
  - If cfg_enable & fifo_count >= BURST_LEN: go to ADDR and assert awvalid the next cycle.
  - If ~cfg_enable: clear FIFO, sts_addr, sts_total, sts_overflow and sts_error every cycle.
- FSM ADDR: awvalid held until awready; then go to DATA.
  - Address, length and ID remain stable while awvalid is high.
- FSM DATA: wvalid = 1 continuously.
  - wdata is the FIFO head; the FIFO pops on wvalid & wready.
  - Occupancy is pre-checked, so the FIFO never underflows and wvalid never drops mid-burst.
  - Beat counter 0..BURST_LEN-1; wlast on beat BURST_LEN-1.
  - sts_addr and sts_total increment on each accepted beat.
  - After the last beat: go to RESP.
- FSM RESP: bready = 1.
  - On bvalid: wid increments (wraps), sts_error |= (bresp != 0), go to IDLE.
  - Only one burst is outstanding at a time.
- cfg_enable falling mid-burst: the current burst completes through RESP; the flush happens in IDLE.
- AW field encodings:
  - awaddr = cfg_base + (sts_addr << log2(AXI_DATA_WIDTH/8)), latched on entering ADDR.
  - awlen = BURST_LEN-1; awsize = log2(AXI_DATA_WIDTH/8); awburst = INCR; awcache = 4'b0011.
  - awid = wid = wid counter.
- W fields: wstrb all ones.
- Wrap: sts_addr wraps modulo 2^ADDR_WIDTH. Bursts are aligned and never cross the ring end. The burst after the last slot writes cfg_base. sts_total wraps at 2^COUNTER_WIDTH.
- Simultaneous push and pop: occupancy unchanged; full and empty are evaluated on the registered count.
- Reset asserted mid-burst: outputs go to reset values immediately, with no bus completion; the system resets the interconnect together with this block.

Test Plan:
1. Enable, base 0x1000_0000, 32 beats 0..31, awready/wready/bvalid tied 1 -> two bursts at 0x1000_0000 and 0x1000_0080, awid 0 then 1; wlast on data 15 and 31; sts_total=32, sts_addr=32.
2. 10 beats only -> no awvalid, sts_busy=0; 6 more beats -> one burst, data 0..15 in order.
3. ADDR_WIDTH=5, 48 beats -> third burst awaddr = base again; final sts_addr=16, sts_total=48.
4. awready delayed 5 cycles, wready random 50% -> data order preserved, awaddr stable while awvalid, wvalid never drops mid-burst; tvalid held with wready=0 until FIFO full -> sts_overflow=1.
5. bresp=2'b10 on second burst -> sts_error=1; drop cfg_enable -> FIFO flushed, counters and flags 0; re-enable -> next burst at base.
6. BURST_LEN=4, AXI_DATA_WIDTH=32 -> awlen=3, awsize=2, address step 16 bytes. aresetn low mid-DATA -> awvalid, wvalid and tready go to 0 without waiting for a clock edge.
